vrf_bank_scheduler: RTL

VRF_BANK_SCHEDULER -- requirements
Module: vrf_bank_scheduler

---
 rtl/vrf_bank_scheduler_if.sv | 83 ++++++++
 rtl/vrf_bank_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_bank_scheduler_if.sv
// Shared types and the bus interface for the VRF bank scheduler.
//
// vrf_bank_scheduler_pkg
//    ELEN       element width in bits
//    opqueue_e  operand queue a bank read is steered to
//
// vrf_bank_scheduler_if
//    Requester side : req_i, bank_i, addr_i, wen_i, wdata_i, be_i, opqueue_i -> gnt_o
//    Permutation    : perm_req_i, perm_addr_i, perm_len_i, perm_opqueue_i
//                     -> perm_gnt_o, perm_busy_o, perm_done_o
//    Bank side      : vrf_req_o, vrf_addr_o, vrf_wen_o, vrf_wdata_o, vrf_be_o,
//                     vrf_tgt_opqueue_o
//    Modports       : master (traffic source / bank sink), slave (scheduler)

package vrf_bank_scheduler_pkg;

   parameter int unsigned ELEN = 64;

   typedef enum logic [2:0] {
      AluA,
      AluB,
      MulFpuA,
      MulFpuB,
      MaskB,
      StA,
      PermIdx,
      PermVal
   } opqueue_e;

endpackage

interface vrf_bank_scheduler_if #(
   parameter int unsigned NrBanks      = 8,
   parameter int unsigned NrRequesters = 4,
   parameter int unsigned AddrWidth    = 16,
   parameter int unsigned LenWidth     = 4
);
   import vrf_bank_scheduler_pkg::*;

   localparam int unsigned BankWidth = (NrBanks > 1) ? $clog2(NrBanks) : 1;

   // Single-bank requesters
   logic     [NrRequesters-1:0]                 req_i;
   logic     [NrRequesters-1:0][BankWidth-1:0]  bank_i;
   logic     [NrRequesters-1:0][AddrWidth-1:0]  addr_i;
   logic     [NrRequesters-1:0]                 wen_i;
   logic     [NrRequesters-1:0][ELEN-1:0]       wdata_i;
   logic     [NrRequesters-1:0][ELEN/8-1:0]     be_i;
   opqueue_e [NrRequesters-1:0]                 opqueue_i;
   logic     [NrRequesters-1:0]                 gnt_o;

   // All-bank permutation burst
   logic                                        perm_req_i;
   logic     [AddrWidth-1:0]                    perm_addr_i;
   logic     [LenWidth-1:0]                     perm_len_i;
   opqueue_e                                    perm_opqueue_i;
   logic                                        perm_gnt_o;
   logic                                        perm_busy_o;
   logic                                        perm_done_o;

   // Bank ports
   logic     [NrBanks-1:0]                      vrf_req_o;
   logic     [NrBanks-1:0][AddrWidth-1:0]       vrf_addr_o;
   logic     [NrBanks-1:0]                      vrf_wen_o;
   logic     [NrBanks-1:0][ELEN-1:0]            vrf_wdata_o;
   logic     [NrBanks-1:0][ELEN/8-1:0]          vrf_be_o;
   opqueue_e [NrBanks-1:0]                      vrf_tgt_opqueue_o;

   modport master (
      output req_i, bank_i, addr_i, wen_i, wdata_i, be_i, opqueue_i,
      output perm_req_i, perm_addr_i, perm_len_i, perm_opqueue_i,
      input  gnt_o, perm_gnt_o, perm_busy_o, perm_done_o,
      input  vrf_req_o, vrf_addr_o, vrf_wen_o, vrf_wdata_o, vrf_be_o, vrf_tgt_opqueue_o
   );

   modport slave (
      input  req_i, bank_i, addr_i, wen_i, wdata_i, be_i, opqueue_i,
      input  perm_req_i, perm_addr_i, perm_len_i, perm_opqueue_i,
      output gnt_o, perm_gnt_o, perm_busy_o, perm_done_o,
      output vrf_req_o, vrf_addr_o, vrf_wen_o, vrf_wdata_o, vrf_be_o, vrf_tgt_opqueue_o
   );

endinterface

// File: rtl/vrf_bank_scheduler.sv
// VRF bank scheduler.
//
// Arbitrates single-bank requesters onto the VRF banks with a per-bank round-robin
// pointer, and interleaves all-bank permutation read bursts that take every bank for
// perm_len_i+1 cycles. A pending burst waits while normal traffic is present, but is
// forced through after StarveLimit cycles.
//
// Ports
//    clk_i  clock
//    rst_i  asynchronous active-high reset (also forces all outputs to zero)
//    bus    vrf_bank_scheduler_if slave: requester, permutation and bank signals
//
// Grants and bank outputs are combinational in the request cycle.

module vrf_bank_scheduler
   import vrf_bank_scheduler_pkg::*;
#(
   parameter int unsigned NrBanks      = 8,
   parameter int unsigned NrRequesters = 4,
   parameter int unsigned AddrWidth    = 16,
   parameter int unsigned LenWidth     = 4,
   parameter int unsigned StarveLimit  = 4
) (
   input logic                  clk_i,
   input logic                  rst_i,
   vrf_bank_scheduler_if.slave  bus
);

   localparam int unsigned ReqIdxW = (NrRequesters > 1) ? $clog2(NrRequesters) : 1;
   localparam int unsigned WaitW   = $clog2(StarveLimit + 1);

   typedef enum logic [1:0] {StIdle, StPend, StBurst} state_e;

   state_e                            state_q, state_d;
   logic [WaitW-1:0]                  wait_cnt_q, wait_cnt_d;
   logic [LenWidth-1:0]               beat_cnt_q, beat_cnt_d;
   logic [LenWidth-1:0]               len_q, len_d;
   logic [AddrWidth-1:0]              base_q, base_d;
   opqueue_e                          opq_q, opq_d;
   logic [NrBanks-1:0][ReqIdxW-1:0]   rr_q, rr_d;

   logic [NrBanks-1:0]                bank_gnt;
   logic [NrBanks-1:0][ReqIdxW-1:0]   bank_win;
   logic                              any_req;
   logic                              accept;
   logic                              done;
   logic                              perm_active;
   logic [AddrWidth-1:0]              beat_addr;
   opqueue_e                          beat_opq;

   assign any_req = |bus.req_i;

   // Per-bank round-robin: first requester at or after rr_q[b], searching cyclically.
   always_comb begin
      bank_gnt = '0;
      bank_win = '0;
      for (int b = 0; b < int'(NrBanks); b++) begin
         for (int i = 0; i < int'(NrRequesters); i++) begin
            int idx;
            idx = (int'(rr_q[b]) + i) % int'(NrRequesters);
            if (!bank_gnt[b] && bus.req_i[idx] && (int'(bus.bank_i[idx]) == b)) begin
               bank_gnt[b] = 1'b1;
               bank_win[b] = ReqIdxW'(idx);
            end
         end
      end
   end

   // Permutation FSM next state
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      base_d     = base_q;
      opq_d      = opq_q;
      accept     = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.perm_req_i) begin
               if (!any_req) begin
                  accept = 1'b1;
               end else begin
                  state_d    = StPend;
                  wait_cnt_d = WaitW'(1);
               end
            end
         end
         StPend: begin
            if (!bus.perm_req_i) begin
               // Requester withdrew before being served
               state_d    = StIdle;
               wait_cnt_d = '0;
            end else if (!any_req || (wait_cnt_q == WaitW'(StarveLimit))) begin
               accept = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
         end
         StBurst: begin
            if (beat_cnt_q == len_q) begin
               done       = 1'b1;
               state_d    = StIdle;
               beat_cnt_d = '0;
            end else begin
               beat_cnt_d = beat_cnt_q + LenWidth'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Accept issues beat 0 from the live inputs and latches the burst descriptor.
      if (accept) begin
         wait_cnt_d = '0;
         base_d     = bus.perm_addr_i;
         len_d      = bus.perm_len_i;
         opq_d      = bus.perm_opqueue_i;
         if (bus.perm_len_i == '0) begin
            done       = 1'b1;
            state_d    = StIdle;
            beat_cnt_d = '0;
         end else begin
            state_d    = StBurst;
            beat_cnt_d = LenWidth'(1);
         end
      end
   end

   assign perm_active = accept || (state_q == StBurst);
   assign beat_addr   = accept ? bus.perm_addr_i : (base_q + AddrWidth'(beat_cnt_q));
   assign beat_opq    = accept ? bus.perm_opqueue_i : opq_q;

   // Round-robin pointers are frozen while the banks belong to a burst.
   always_comb begin
      rr_d = rr_q;
      if (!perm_active) begin
         for (int b = 0; b < int'(NrBanks); b++) begin
            if (bank_gnt[b]) begin
               rr_d[b] = ReqIdxW'((int'(bank_win[b]) + 1) % int'(NrRequesters));
            end
         end
      end
   end

   // Outputs; everything is held at zero while reset is asserted.
   always_comb begin
      bus.gnt_o             = '0;
      bus.vrf_req_o         = '0;
      bus.vrf_addr_o        = '0;
      bus.vrf_wen_o         = '0;
      bus.vrf_wdata_o       = '0;
      bus.vrf_be_o          = '0;
      bus.vrf_tgt_opqueue_o = {NrBanks{AluA}};
      bus.perm_gnt_o        = 1'b0;
      bus.perm_busy_o       = 1'b0;
      bus.perm_done_o       = 1'b0;
      if (!rst_i) begin
         bus.perm_gnt_o  = accept;
         bus.perm_busy_o = (state_q == StBurst);
         bus.perm_done_o = done;
         if (perm_active) begin
            for (int b = 0; b < int'(NrBanks); b++) begin
               bus.vrf_req_o[b]         = 1'b1;
               bus.vrf_addr_o[b]        = beat_addr;
               bus.vrf_tgt_opqueue_o[b] = beat_opq;
            end
         end else begin
            for (int b = 0; b < int'(NrBanks); b++) begin
               if (bank_gnt[b]) begin
                  bus.gnt_o[bank_win[b]]   = 1'b1;
                  bus.vrf_req_o[b]         = 1'b1;
                  bus.vrf_addr_o[b]        = bus.addr_i[bank_win[b]];
                  bus.vrf_wen_o[b]         = bus.wen_i[bank_win[b]];
                  bus.vrf_wdata_o[b]       = bus.wdata_i[bank_win[b]];
                  bus.vrf_be_o[b]          = bus.be_i[bank_win[b]];
                  bus.vrf_tgt_opqueue_o[b] = bus.opqueue_i[bank_win[b]];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         beat_cnt_q <= '0;
         len_q      <= '0;
         base_q     <= '0;
         opq_q      <= AluA;
         rr_q       <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         base_q     <= base_d;
         opq_q      <= opq_d;
         rr_q       <= rr_d;
      end
   end

   // Permutation queues are reserved for bursts; bursts only target them.
   logic bad_opqueue;
   logic bad_perm_opqueue;

   always_comb begin
      bad_opqueue = 1'b0;
      for (int r = 0; r < int'(NrRequesters); r++) begin
         if (bus.opqueue_i[r] inside {PermIdx, PermVal}) bad_opqueue = 1'b1;
      end
   end

   assign bad_perm_opqueue = bus.perm_req_i && !(bus.perm_opqueue_i inside {PermIdx, PermVal});

   a_opqueue_not_perm : assert property (@(posedge clk_i) disable iff (rst_i) !bad_opqueue)
      else $error("single-bank requester targets a permutation operand queue");
   a_perm_opqueue_is_perm : assert property (@(posedge clk_i) disable iff (rst_i)
      !bad_perm_opqueue)
      else $error("permutation burst targets a non-permutation operand queue");

endmodule
